wx_mem_reader: RTL and testbench

- Read-side counterpart of the weight/input load path. The load path writes 1-bit weights and inputs into the banked memory system using w_sel/w_addr/w_wq and x_sel/x_addr/x_wq.
- This block reads them back for one layer. For every output neuron it walks the fan-in and streams (weight bit, input bit) pairs to the compute datapath through a valid/ready handshake.
- It sits between the memory system and the XNOR-popcount compute module, and drives the memory's compute-side ports while load_compute_ctrl=0.

---
 rtl/wx_mem_pkg.sv | 38 +++
 rtl/wx_pair_fifo.sv | 70 +++++++
 rtl/wx_mem_reader.sv | 194 +++++++++++++++++++
 tb/tb_wx_mem_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wx_mem_pkg.sv
// -----------------------------------------------------------------------------
// wx_mem_pkg
// Shared definitions for the weight/input memory read path:
//   - default address / bank-select widths used by the banked memory system
//   - read-controller FSM state encoding
//   - layout of one return-data FIFO entry and of the per-read tag
// -----------------------------------------------------------------------------
package wx_mem_pkg;

    localparam int W_ADDR_LEN_DEF = 20;
    localparam int X_ADDR_LEN_DEF = 10;
    localparam int W_SEL_LEN_DEF  = 2;
    localparam int X_SEL_LEN_DEF  = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    // Width of one FIFO entry: {w, x, last_in, last}
    localparam int PAIR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic w;
        logic x;
        logic last_in;
        logic last;
    } pair_entry_t;

    // Markers that travel with a read while it is in flight to the memory
    typedef struct packed {
        logic last_in;
        logic last;
    } read_tag_t;

endpackage

// File: rtl/wx_pair_fifo.sv
// -----------------------------------------------------------------------------
// wx_pair_fifo
// Small synchronous FIFO holding returned (weight, input) pairs.
// Ports:
//   clk, rst_n_i       clock, asynchronous active-low reset (empties the FIFO)
//   push_i, data_i     write side (push ignored when full)
//   pop_i              read side (pop ignored when empty)
//   data_o             current head entry (valid while empty_o = 0)
//   empty_o            no entries stored
//   count_o            number of stored entries
// -----------------------------------------------------------------------------
module wx_pair_fifo
    import wx_mem_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = PAIR_W
) (
    input  logic                     clk,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through a valid head
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Head is read combinationally so a pushed pair is visible the next cycle
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wx_mem_reader.sv
// -----------------------------------------------------------------------------
// wx_mem_reader
// Reads one layer's 1-bit weights and inputs back from the banked memory and
// streams (weight, input) pairs to the compute datapath, neuron by neuron.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   start, layer_*_sel, n_in,  layer request (ignored while busy)
//   n_out
//   w_addr/w_sel/w_wq/w_data   weight memory read port (w_wq tied 0)
//   x_addr/x_sel/x_wq/x_data   input memory read port (x_wq tied 0)
//   pair_*                     valid/ready pair stream with neuron/layer ends
//   busy, done                 layer in progress, completion pulse
// Memory returns data one cycle after the registered address, so a read is
// captured two edges after it is issued. Reads are only issued when the FIFO
// is guaranteed room for them (stored + in-flight < depth).
// -----------------------------------------------------------------------------
module wx_mem_reader
    import wx_mem_pkg::*;
#(
    parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
    parameter int X_ADDR_LEN = X_ADDR_LEN_DEF,
    parameter int W_SEL_LEN  = W_SEL_LEN_DEF,
    parameter int X_SEL_LEN  = X_SEL_LEN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W_SEL_LEN-1:0]  layer_w_sel,
    input  logic [X_SEL_LEN-1:0]  layer_x_sel,
    input  logic [X_ADDR_LEN-1:0] n_in,
    input  logic [X_ADDR_LEN-1:0] n_out,
    output logic [W_ADDR_LEN-1:0] w_addr,
    output logic [W_SEL_LEN-1:0]  w_sel,
    output logic                  w_wq,
    input  logic                  w_data,
    output logic [X_ADDR_LEN-1:0] x_addr,
    output logic [X_SEL_LEN-1:0]  x_sel,
    output logic                  x_wq,
    input  logic                  x_data,
    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic                  pair_w,
    output logic                  pair_x,
    output logic                  pair_last_in,
    output logic                  pair_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    rd_state_e             state_q;
    logic [X_ADDR_LEN-1:0] n_in_q;
    logic [X_ADDR_LEN-1:0] n_out_q;
    logic [X_ADDR_LEN-1:0] i_q;
    logic [X_ADDR_LEN-1:0] j_q;
    logic [X_ADDR_LEN-1:0] x_addr_q;
    logic [W_ADDR_LEN-1:0] w_cnt_q;
    logic [W_ADDR_LEN-1:0] w_addr_q;
    logic [W_SEL_LEN-1:0]  w_sel_q;
    logic [X_SEL_LEN-1:0]  x_sel_q;
    logic [1:0]            tag_q;     // [0]: address on the bus, [1]: data returning
    read_tag_t             meta0_q;
    read_tag_t             meta1_q;
    logic                  busy_q;
    logic                  done_q;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [PAIR_W-1:0]     head_bits;
    pair_entry_t           head;
    pair_entry_t           push_entry;
    logic [1:0]            inflight;
    logic                  credit_ok;
    logic                  issue;
    logic                  last_i;
    logic                  last_j;
    logic                  pop;

    assign inflight  = {1'b0, tag_q[0]} + {1'b0, tag_q[1]};
    assign credit_ok = ({1'b0, fifo_count} + (CW + 1)'(inflight)) < DEPTH_C;
    assign issue     = (state_q == ST_RUN) && credit_ok;
    assign last_i    = (i_q == (n_in_q - X_ADDR_LEN'(1)));
    assign last_j    = (j_q == (n_out_q - X_ADDR_LEN'(1)));
    assign pop       = !fifo_empty && pair_ready;

    assign push_entry = '{w: w_data, x: x_data,
                          last_in: meta1_q.last_in, last: meta1_q.last};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            n_in_q   <= '0;
            n_out_q  <= '0;
            i_q      <= '0;
            j_q      <= '0;
            x_addr_q <= '0;
            w_cnt_q  <= '0;
            w_addr_q <= '0;
            w_sel_q  <= '0;
            x_sel_q  <= '0;
            tag_q    <= '0;
            meta0_q  <= '0;
            meta1_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            tag_q   <= {tag_q[0], issue};
            meta1_q <= meta0_q;
            if (issue) meta0_q <= '{last_in: last_i, last: last_i && last_j};

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (n_in != '0 && n_out != '0) begin
                            n_in_q  <= n_in;
                            n_out_q <= n_out;
                            w_sel_q <= layer_w_sel;
                            x_sel_q <= layer_x_sel;
                            i_q     <= '0;
                            j_q     <= '0;
                            w_cnt_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            // Empty layer: nothing to read, just acknowledge
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        // w_cnt_q walks j*n_in+i without a multiplier
                        w_addr_q <= w_cnt_q;
                        x_addr_q <= i_q;
                        w_cnt_q  <= w_cnt_q + W_ADDR_LEN'(1);
                        if (last_i) begin
                            i_q <= '0;
                            j_q <= j_q + X_ADDR_LEN'(1);
                        end else begin
                            i_q <= i_q + X_ADDR_LEN'(1);
                        end
                        if (last_i && last_j) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Empty FIFO with nothing in flight means the last pair was taken
                    if (fifo_empty && tag_q == 2'b00) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    wx_pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n_i (rst),
        .push_i  (tag_q[1]),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_bits),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head = pair_entry_t'(head_bits);

    // Pair fields are forced low while empty so stale storage never shows
    assign pair_valid   = !fifo_empty;
    assign pair_w       = head.w       && !fifo_empty;
    assign pair_x       = head.x       && !fifo_empty;
    assign pair_last_in = head.last_in && !fifo_empty;
    assign pair_last    = head.last    && !fifo_empty;

    assign w_addr = w_addr_q;
    assign x_addr = x_addr_q;
    assign w_sel  = w_sel_q;
    assign x_sel  = x_sel_q;
    assign w_wq   = 1'b0;
    assign x_wq   = 1'b0;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_wx_mem_reader.sv
module tb_wx_mem_reader;

    localparam int WA = 20;
    localparam int XA = 10;
    localparam int WS = 2;
    localparam int XS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WS-1:0] layer_w_sel;
    logic [XS-1:0] layer_x_sel;
    logic [XA-1:0] n_in;
    logic [XA-1:0] n_out;
    logic [WA-1:0] w_addr;
    logic [WS-1:0] w_sel;
    logic          w_wq;
    logic          w_data = 1'b0;
    logic [XA-1:0] x_addr;
    logic [XS-1:0] x_sel;
    logic          x_wq;
    logic          x_data = 1'b0;
    logic          pair_valid;
    logic          pair_ready;
    logic          pair_w;
    logic          pair_x;
    logic          pair_last_in;
    logic          pair_last;
    logic          busy;
    logic          done;

    wx_mem_reader #(
        .W_ADDR_LEN(WA), .X_ADDR_LEN(XA), .W_SEL_LEN(WS), .X_SEL_LEN(XS), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .layer_w_sel(layer_w_sel), .layer_x_sel(layer_x_sel),
        .n_in(n_in), .n_out(n_out),
        .w_addr(w_addr), .w_sel(w_sel), .w_wq(w_wq), .w_data(w_data),
        .x_addr(x_addr), .x_sel(x_sel), .x_wq(x_wq), .x_data(x_data),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_w(pair_w), .pair_x(pair_x),
        .pair_last_in(pair_last_in), .pair_last(pair_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory model: address presented in a cycle returns data the next cycle
    logic wmem [4][64];
    logic xmem [4][64];
    always @(posedge clk) begin
        w_data <= wmem[w_sel][w_addr[5:0]];
        x_data <= xmem[x_sel][x_addr[5:0]];
    end

    typedef struct packed {
        logic w;
        logic x;
        logic li;
        logic l;
    } pair_t;

    typedef struct {
        int          n_in;
        int          n_out;
        int          wsel;
        int          xsel;
        int          stall;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
        int          spur;    // pulse a second start mid-layer
        int          npairs;
        logic [15:0] ew;      // bit k = expected field of pair k
        logic [15:0] ex;
        logic [15:0] eli;
        logic [15:0] el;
    } vec_t;

    pair_t expq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic run_layer(input int ni, input int no, input int ws, input int xs,
                             input int stall, input int spur);
        int            npairs;
        int            cyc;
        int            acc;
        int            done_cnt;
        int            last_acc;
        bit            first_seen;
        bit            prev_stall;
        logic [3:0]    prev_pair;
        logic          r;
        pair_t         e;
        logic [WA-1:0] w_before;
        logic [XA-1:0] x_before;
        npairs = expq.size();
        acc = 0; done_cnt = 0; last_acc = -10; first_seen = 0; prev_stall = 0;
        prev_pair = '0;
        @(negedge clk);
        w_before    = w_addr;
        x_before    = x_addr;
        layer_w_sel = WS'(ws);
        layer_x_sel = XS'(xs);
        n_in        = XA'(ni);
        n_out       = XA'(no);
        pair_ready  = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("layer n_in=%0d n_out=%0d w_sel=%0d x_sel=%0d stall=%0d", ni, no, ws, xs, stall);
        cyc = 0;
        while (cyc < 300) begin
            if (cyc == 0) begin
                check("busy_after_start", busy, npairs > 0);
                if (npairs > 0) check("sel_latch", {w_sel, x_sel}, {WS'(ws), XS'(xs)});
            end
            if (pair_valid && !first_seen) begin
                first_seen = 1;
                check("first_valid_latency", cyc, 3);
            end
            if (prev_stall)
                check("head_stable", {pair_valid, pair_w, pair_x, pair_last_in, pair_last},
                      {1'b1, prev_pair});
            if (busy && cyc > 0 && x_addr >= XA'(ni))
                check("x_addr_range", x_addr, ni - 1);
            if (dut.u_fifo.count_o > 4) check("fifo_count_bound", dut.u_fifo.count_o, 4);
            if (done) begin
                done_cnt++;
                check("done_timing", cyc, (npairs == 0) ? 0 : last_acc + 2);
                check("busy_at_done", busy, 0);
                break;
            end
            case (stall)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            pair_ready = r;
            if (spur != 0 && cyc == 4) begin
                start = 1'b1; layer_w_sel = WS'(ws + 1); layer_x_sel = XS'(xs + 1);
                n_in = XA'(2); n_out = XA'(2);
            end else begin
                start = 1'b0;
            end
            if (pair_valid && r) begin
                if (expq.size() == 0) begin
                    check("extra_pair", acc + 1, npairs);
                end else begin
                    e = expq.pop_front();
                    $display("pair %0d: w=%0b x=%0b last_in=%0b last=%0b", acc,
                             pair_w, pair_x, pair_last_in, pair_last);
                    check("pair_data", {pair_w, pair_x, pair_last_in, pair_last}, e);
                end
                if (pair_last) last_acc = cyc;
                acc++;
            end
            prev_stall = pair_valid && !r;
            prev_pair  = {pair_w, pair_x, pair_last_in, pair_last};
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        pair_ready = 1'b0;
        check("done_count", done_cnt, 1);
        check("pair_count", acc, npairs);
        check("wq_tied_low", {w_wq, x_wq}, 0);
        if (npairs > 0) begin
            if (stall == 0) check("full_rate", last_acc, npairs + 2);
            check("final_w_addr", w_addr, ni * no - 1);
            check("final_x_addr", x_addr, ni - 1);
            check("sel_held", {w_sel, x_sel}, {WS'(ws), XS'(xs)});
        end else begin
            check("addr_unchanged", {w_addr, x_addr}, {w_before, x_before});
        end
        expq.delete();
    endtask

    task automatic load_expected(input vec_t v);
        pair_t p;
        for (int k = 0; k < v.npairs; k++) begin
            p = '{w: v.ew[k], x: v.ex[k], li: v.eli[k], l: v.el[k]};
            expq.push_back(p);
        end
    endtask

    // Reference: pair k of neuron j is (W[j*n_in+i], X[i]) in row-major order
    task automatic model_layer(input int ni, input int no, input int ws, input int xs);
        pair_t p;
        for (int j = 0; j < no; j++)
            for (int i = 0; i < ni; i++) begin
                p = '{w: wmem[ws][j * ni + i], x: xmem[xs][i],
                      li: (i == ni - 1), l: (i == ni - 1) && (j == no - 1)};
                expq.push_back(p);
            end
    endtask

    vec_t tbl[6];

    initial begin
        int acc;
        int cyc;
        int ni;
        int no;
        int ws;
        int xs;
        bit quiet;
        tbl[0] = '{3, 2, 1, 2, 0, 0, 6, 16'b001101, 16'b011011, 16'b100100, 16'b100000};
        tbl[1] = '{3, 2, 1, 2, 1, 0, 6, 16'b001101, 16'b011011, 16'b100100, 16'b100000};
        tbl[2] = '{1, 4, 1, 2, 0, 0, 4, 16'b1101,   16'b1111,   16'b1111,   16'b1000};
        tbl[3] = '{3, 0, 1, 2, 0, 0, 0, 16'b0,      16'b0,      16'b0,      16'b0};
        tbl[4] = '{0, 2, 1, 2, 0, 0, 0, 16'b0,      16'b0,      16'b0,      16'b0};
        tbl[5] = '{3, 2, 1, 2, 0, 1, 6, 16'b001101, 16'b011011, 16'b100100, 16'b100000};

        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++) begin
                wmem[b][a] = 1'b0;
                xmem[b][a] = 1'b0;
            end
        wmem[1][0] = 1; wmem[1][1] = 0; wmem[1][2] = 1;
        wmem[1][3] = 1; wmem[1][4] = 0; wmem[1][5] = 0;
        xmem[2][0] = 1; xmem[2][1] = 1; xmem[2][2] = 0;

        rst = 1'b0; start = 1'b0; pair_ready = 1'b0;
        layer_w_sel = '0; layer_x_sel = '0; n_in = '0; n_out = '0;
        @(negedge clk);
        check("reset_state", {pair_valid, busy, done, w_addr, x_addr, w_sel, x_sel,
                              pair_w, pair_x, pair_last_in, pair_last}, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < 6; t++) begin
            load_expected(tbl[t]);
            run_layer(tbl[t].n_in, tbl[t].n_out, tbl[t].wsel, tbl[t].xsel,
                      tbl[t].stall, tbl[t].spur);
        end

        // Reset in the middle of a 3x2 layer, after two pairs were taken
        @(negedge clk);
        layer_w_sel = 2'd1; layer_x_sel = 2'd2; n_in = 3; n_out = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 2 && cyc < 50) begin
            pair_ready = 1'b1;
            if (pair_valid) acc++;
            @(negedge clk);
            cyc++;
        end
        check("reset_test_two_pairs", acc, 2);
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {pair_valid, busy, done, w_addr, x_addr, w_sel, x_sel,
                                      pair_w, pair_x, pair_last_in, pair_last}, 0);
        @(negedge clk);
        rst = 1'b1;
        quiet = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pair_valid || busy || done) quiet = 0;
        end
        check("quiet_after_reset", quiet, 1);
        pair_ready = 1'b0;
        load_expected(tbl[0]);
        run_layer(3, 2, 1, 2, 0, 0);

        // Randomized layers against the reference model
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++) begin
                wmem[b][a] = 1'($urandom_range(0, 1));
                xmem[b][a] = 1'($urandom_range(0, 1));
            end
        for (int t = 0; t < 8; t++) begin
            ni = $urandom_range(1, 6);
            no = $urandom_range(1, 5);
            ws = $urandom_range(0, 3);
            xs = $urandom_range(0, 3);
            model_layer(ni, no, ws, xs);
            run_layer(ni, no, ws, xs, (t % 2 == 0) ? 2 : 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
